mac_feeder: RTL and testbench

- Initiator for the mac accumulate interface (start/valid/a/b in, result out).
- Reads len operand pairs (a[i], b[i]) from two synchronous-read operand memories and streams them into a mac instance as one start beat followed by valid beats.
- After the MAC drains, captures the accumulated result and presents it on a valid/ready output handshake.
- Sits between the layer controller (go/len) and one neuron's mac.

---
 rtl/mac_feeder.sv | 155 +++++++++++++++
 tb/tb_mac_feeder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_feeder.sv
// Operand feeder for one neuron's MAC: streams len (a,b) pairs from two
// synchronous-read memories as a start beat plus valid beats, then returns the result.
module mac_feeder #(
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int N_MAX       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int LEN_WIDTH   = 5,
  parameter int MAC_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 err,
  output logic                 rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [A_WIDTH-1:0]   a_rd_data,
  input  logic [B_WIDTH-1:0]   b_rd_data,
  output logic                 mac_start,
  output logic                 mac_valid,
  output logic [A_WIDTH-1:0]   mac_a,
  output logic [B_WIDTH-1:0]   mac_b,
  input  logic [ACC_WIDTH-1:0] mac_result,
  output logic [ACC_WIDTH-1:0] result_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int LAT_W = $clog2(MAC_LATENCY + 1) + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(N_MAX);

  logic [1:0]            r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_vld_p1;
  logic                  r_first_p1;
  logic                  r_mac_start;
  logic                  r_mac_valid;
  logic [A_WIDTH-1:0]    r_mac_a;
  logic [B_WIDTH-1:0]    r_mac_b;
  logic [ACC_WIDTH-1:0]  r_result;
  logic                  r_out_valid;
  logic                  w_len_ok;
  logic                  w_last_beat;

  assign w_len_ok = (len != '0) && (len <= LEN_MAX);
  // Last beat is on the MAC pins once no read is issued and no read data is pending.
  assign w_last_beat = !r_rd_en && !r_vld_p1 && (r_mac_start || r_mac_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_lat_cnt   <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_vld_p1    <= 1'b0;
      r_first_p1  <= 1'b0;
      r_mac_start <= 1'b0;
      r_mac_valid <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Memory data arrives one cycle after the read; register it onto the MAC pins.
      r_vld_p1    <= r_rd_en;
      r_first_p1  <= r_rd_en && (r_rd_addr == '0);
      r_mac_start <= r_vld_p1 && r_first_p1;
      r_mac_valid <= r_vld_p1 && !r_first_p1;
      r_mac_a     <= r_vld_p1 ? a_rd_data : '0;
      r_mac_b     <= r_vld_p1 ? b_rd_data : '0;
      r_err       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (go) begin
            if (w_len_ok) begin
              r_state   <= S_FETCH;
              r_len     <= len;
              r_cnt     <= LEN_WIDTH'(1);
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
              r_busy    <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (r_cnt < r_len) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_cnt[ADDR_WIDTH-1:0];
            r_cnt     <= r_cnt + LEN_WIDTH'(1);
          end else begin
            r_rd_en <= 1'b0;
          end
          if (w_last_beat) begin
            r_state   <= S_DRAIN;
            r_lat_cnt <= LAT_W'(1);
          end
        end

        S_DRAIN: begin
          if (r_lat_cnt == LAT_W'(MAC_LATENCY)) begin
            r_result    <= mac_result;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign err        = r_err;
  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign mac_start  = r_mac_start;
  assign mac_valid  = r_mac_valid;
  assign mac_a      = r_mac_a;
  assign mac_b      = r_mac_b;
  assign result_out = r_result;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: memories and a MAC around the DUT, a cycle-indexed
// behavioural model of the expected outputs, and directed plus random runs.
module tb_mac_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [4:0]  len;
  logic        busy, err, rd_en;
  logic [3:0]  rd_addr;
  logic [7:0]  a_q, b_q;
  logic        mac_start, mac_valid;
  logic [7:0]  mac_a, mac_b;
  logic signed [31:0] acc;
  logic [31:0] result_out;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  logic signed [7:0] mem_a [16];
  logic signed [7:0] mem_b [16];

  always #5 clk = ~clk;

  mac_feeder dut (
    .clk(clk), .rst(rst), .go(go), .len(len), .busy(busy), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_rd_data(a_q), .b_rd_data(b_q),
    .mac_start(mac_start), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(acc), .result_out(result_out), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Synchronous-read operand memories and a latency-1 MAC.
  always @(posedge clk) begin
    if (rd_en) begin
      a_q <= mem_a[rd_addr];
      b_q <= mem_b[rd_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) acc <= 0;
    else if (mac_start) acc <= $signed(mac_a) * $signed(mac_b);
    else if (mac_valid) acc <= acc + $signed(mac_a) * $signed(mac_b);
  end

  // Model: position within a run (m_k = edges since the accepting edge).
  bit          m_active = 1'b0;
  bit          m_err = 1'b0;
  int          m_k = 0;
  int          m_len = 0;
  logic [31:0] m_sum = 0;

  function automatic logic [31:0] dot(input int l);
    int s = 0;
    for (int i = 0; i < l; i++) s += int'(mem_a[i]) * int'(mem_b[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_err    <= 1'b0;
    end else if (!m_active) begin
      m_err <= 1'b0;
      if (go) begin
        if (len >= 5'd1 && len <= 5'd16) begin
          m_active <= 1'b1;
          m_k      <= 1;
          m_len    <= int'(len);
          m_sum    <= dot(int'(len));
        end else begin
          m_err <= 1'b1;
        end
      end
    end else begin
      m_err <= 1'b0;
      if (m_k >= m_len + 4 && out_ready) m_active <= 1'b0;
      else m_k <= m_k + 1;
    end
  end

  function automatic bit f_rd();
    return m_active && m_k >= 1 && m_k <= m_len;
  endfunction
  function automatic bit f_beat();
    return m_active && m_k >= 3 && m_k <= m_len + 2;
  endfunction
  function automatic bit f_start();
    return m_active && m_k == 3;
  endfunction
  function automatic bit f_ov();
    return m_active && m_k >= m_len + 4;
  endfunction
  function automatic logic [7:0] f_a();
    logic [7:0] v = 8'd0;
    if (f_beat()) v = mem_a[m_k - 3];
    return v;
  endfunction
  function automatic logic [7:0] f_b();
    logic [7:0] v = 8'd0;
    if (f_beat()) v = mem_b[m_k - 3];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, f_rd() || m_active);
      chk("err", err, m_err);
      chk("rd_en", rd_en, f_rd());
      if (f_rd()) chk("rd_addr", rd_addr, m_k - 1);
      chk("mac_start", mac_start, f_start());
      chk("mac_valid", mac_valid, f_beat() && !f_start());
      chk("mac_a", mac_a, f_a());
      chk("mac_b", mac_b, f_b());
      chk("out_valid", out_valid, f_ov());
      if (f_ov()) chk("result_out", result_out, m_sum);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int l, input logic [31:0] exp_res, input int hold);
    int c;
    bit seen;
    out_ready = (hold == 0);
    go = 1'b1;
    len = 5'(l);
    tick();
    go = 1'b0;
    len = 5'd0;
    chk("model_sum", m_sum, exp_res);
    c = 1;
    seen = 1'b0;
    while (!seen && c <= 40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        tick();
        c++;
      end
    end
    chk("ov_seen", 32'(seen), 1);
    chk("ov_cycle", c, l + 4);
    chk("result_lit", result_out, exp_res);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        go = (i == 3);
        len = 5'd2;
        chk("hold_valid", out_valid, 1);
        chk("hold_result", result_out, exp_res);
      end
      go = 1'b0;
      len = 5'd0;
      out_ready = 1'b1;
    end
    tick();
    chk("post_xfer_valid", out_valid, 0);
    chk("post_xfer_busy", busy, 0);
    out_ready = 1'b0;
  endtask

  task automatic run_rand();
    int l;
    int c;
    if ($urandom_range(0, 3) == 0) begin
      go = 1'b1;
      len = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
      tick();
      go = 1'b0;
      chk("rand_err", err, 1);
    end
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    l = $urandom_range(1, 16);
    go = 1'b1;
    len = 5'(l);
    tick();
    c = 0;
    while (c < 200) begin
      tick();
      if (!busy) begin
        go = 1'b0;
        break;
      end
      go = ($urandom_range(0, 3) == 0);
      len = 5'($urandom_range(0, 31));
      out_ready = 1'($urandom_range(0, 1));
      c++;
    end
    go = 1'b0;
    out_ready = 1'b0;
    chk("rand_done", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    len = 5'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'sd0;
      mem_b[i] = 8'sd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result_out, 0);
    tick();

    // Basic dot product
    mem_a[0] = 3;  mem_a[1] = -1; mem_a[2] = 4;  mem_a[3] = 1;
    mem_b[0] = 2;  mem_b[1] = 5;  mem_b[2] = -2; mem_b[3] = 10;
    run(4, 32'd3, 0);

    // Length one with most-negative operands
    mem_a[0] = -128;
    mem_b[0] = -128;
    run(1, 32'd16384, 0);

    // Bad lengths
    go = 1'b1; len = 5'd0;
    tick();
    go = 1'b0;
    chk("err_len0", err, 1);
    chk("err_len0_busy", busy, 0);
    tick();
    chk("err_len0_clear", err, 0);
    go = 1'b1; len = 5'd17;
    tick();
    go = 1'b0;
    chk("err_len17", err, 1);
    chk("err_len17_rd_en", rd_en, 0);
    tick();
    chk("err_len17_clear", err, 0);

    // Backpressure with a go pulse during HOLD
    mem_a[0] = 3;  mem_a[1] = -1; mem_a[2] = 4;  mem_a[3] = 1;
    mem_b[0] = 2;  mem_b[1] = 5;  mem_b[2] = -2; mem_b[3] = 10;
    run(4, 32'd3, 10);
    tick();
    chk("bp_idle_busy", busy, 0);

    // Reset in cycle 5 of a len=8 run
    out_ready = 1'b1;
    go = 1'b1; len = 5'd8;
    tick();
    go = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_mac_start", mac_start, 0);
    chk("midrst_mac_valid", mac_valid, 0);
    chk("midrst_mac_a", mac_a, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result_out, 0);
    chk("midrst_err", err, 0);
    out_ready = 1'b0;
    mem_a[0] = 1; mem_a[1] = 1;
    mem_b[0] = 7; mem_b[1] = -3;
    run(2, 32'd4, 0);

    // Full length
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 127;
      mem_b[i] = 127;
    end
    run(16, 32'd258064, 0);

    for (int r = 0; r < 25; r++) run_rand();

    tick();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
